// File: rtl/hex_display_pkg.sv
// Shared types and constants for the seven-segment display output stage.
// Segment patterns are active-low with bit order {g,f,e,d,c,b,a}.
package hex_display_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        LOAD
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    localparam logic [6:0] SEG_0 = 7'b1000000;
    localparam logic [6:0] SEG_1 = 7'b1111001;
    localparam logic [6:0] SEG_2 = 7'b0100100;
    localparam logic [6:0] SEG_3 = 7'b0110000;
    localparam logic [6:0] SEG_4 = 7'b0011001;
    localparam logic [6:0] SEG_5 = 7'b0010010;
    localparam logic [6:0] SEG_6 = 7'b0000010;
    localparam logic [6:0] SEG_7 = 7'b1111000;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0010000;
    localparam logic [6:0] SEG_A = 7'b0001000;
    localparam logic [6:0] SEG_B = 7'b0000011;
    localparam logic [6:0] SEG_C = 7'b1000110;
    localparam logic [6:0] SEG_D = 7'b0100001;
    localparam logic [6:0] SEG_E = 7'b0000110;
    localparam logic [6:0] SEG_F = 7'b0001110;

    // Largest value that fits in eight decimal digits.
    localparam logic [31:0] DEC_MAX = 32'd99_999_999;

    localparam int DIGITS = 8;
    localparam int BCD_W  = 40;

endpackage

// File: rtl/seg7_encode.sv
// Combinational nibble to seven-segment pattern map (0-9, A-F).
// Ports:
//   nib  in  4  value to render
//   seg  out 7  active-low segments {g,f,e,d,c,b,a}
module seg7_encode
    import hex_display_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (nib)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
            4'hA: seg = SEG_A;
            4'hB: seg = SEG_B;
            4'hC: seg = SEG_C;
            4'hD: seg = SEG_D;
            4'hE: seg = SEG_E;
            4'hF: seg = SEG_F;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/hex_bcd_display.sv
// Display output stage: accepts a 32-bit value over valid/ready and drives
// eight registered seven-segment digits, either as raw hex or as decimal
// via a one-bit-per-cycle double-dabble conversion.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   in_valid/in_data/in_dec  value handshake; in_dec selects decimal mode
//   in_ready, busy  idle indication and its complement
//   ovf             last accepted decimal value exceeded 99_999_999
//   HEX0..HEX7      active-low segments, HEX0 least-significant digit
module hex_bcd_display
    import hex_display_pkg::*;
#(
    parameter bit BLANK_LZ = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [31:0] in_data,
    input  logic        in_dec,
    output logic        in_ready,
    output logic        busy,
    output logic        ovf,
    output logic [6:0]  HEX0,
    output logic [6:0]  HEX1,
    output logic [6:0]  HEX2,
    output logic [6:0]  HEX3,
    output logic [6:0]  HEX4,
    output logic [6:0]  HEX5,
    output logic [6:0]  HEX6,
    output logic [6:0]  HEX7
);

    localparam logic [6:0] SEG_UPPER_RST = BLANK_LZ ? SEG_BLANK : SEG_0;

    state_t             state, state_n;
    logic [4:0]         cnt;
    logic [BCD_W-1:0]   bcd;
    logic [BCD_W-1:0]   bcd_adj;
    logic [31:0]        bin;
    logic               dec_q;
    logic               big_q;
    logic [6:0]         seg_q   [DIGITS];
    logic [6:0]         seg_enc [DIGITS];
    logic [3:0]         nib     [DIGITS];
    logic [DIGITS-1:0]  lz;
    logic               accept;

    assign in_ready = (state == IDLE);
    assign busy     = !in_ready;
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: if (accept) state_n = in_dec ? CONV : LOAD;
            CONV: if (cnt == 5'd31) state_n = LOAD;
            LOAD: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Double-dabble correction: any BCD nibble >= 5 gets +3 before the shift.
    always_comb begin
        bcd_adj = bcd;
        for (int k = 0; k < BCD_W / 4; k++) begin
            if (bcd[4*k +: 4] >= 4'd5) begin
                bcd_adj[4*k +: 4] = bcd[4*k +: 4] + 4'd3;
            end
        end
    end

    // lz[i] is set when digit i and every digit above it are zero.
    always_comb begin
        lz = '1;
        for (int i = 0; i < DIGITS; i++) begin
            for (int j = i; j < DIGITS; j++) begin
                if (bcd[4*j +: 4] != 4'd0) lz[i] = 1'b0;
            end
        end
    end

    // In hex mode bin is untouched since accept, so it still holds the value.
    always_comb begin
        for (int i = 0; i < DIGITS; i++) begin
            nib[i] = dec_q ? bcd[4*i +: 4] : bin[4*i +: 4];
        end
    end

    for (genvar g = 0; g < DIGITS; g++) begin : g_enc
        seg7_encode u_enc (
            .nib (nib[g]),
            .seg (seg_enc[g])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            bcd      <= '0;
            ovf      <= 1'b0;
            seg_q[0] <= SEG_0;
            for (int i = 1; i < DIGITS; i++) seg_q[i] <= SEG_UPPER_RST;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        bin   <= in_data;
                        dec_q <= in_dec;
                        big_q <= (in_data > DEC_MAX);
                        cnt   <= '0;
                        bcd   <= '0;
                    end
                end
                CONV: begin
                    bcd <= {bcd_adj[BCD_W-2:0], bin[31]};
                    bin <= {bin[30:0], 1'b0};
                    cnt <= cnt + 5'd1;
                end
                LOAD: begin
                    ovf <= dec_q && big_q;
                    for (int i = 0; i < DIGITS; i++) begin
                        if (dec_q && big_q)
                            seg_q[i] <= SEG_DASH;
                        else if (BLANK_LZ && dec_q && (i != 0) && lz[i])
                            seg_q[i] <= SEG_BLANK;
                        else
                            seg_q[i] <= seg_enc[i];
                    end
                end
                default: ;
            endcase
        end
    end

    assign HEX0 = seg_q[0];
    assign HEX1 = seg_q[1];
    assign HEX2 = seg_q[2];
    assign HEX3 = seg_q[3];
    assign HEX4 = seg_q[4];
    assign HEX5 = seg_q[5];
    assign HEX6 = seg_q[6];
    assign HEX7 = seg_q[7];

endmodule

// File: tb/tb_hex_bcd_display.sv
module tb_hex_bcd_display;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_dec;

    logic        rdy1, busy1, ovf1;
    logic        rdy0, busy0, ovf0;
    wire  [55:0] disp1;
    wire  [55:0] disp0;

    int n_vec = 0;
    int n_err = 0;

    typedef struct packed {
        logic [55:0] h1;
        logic [55:0] h0;
        logic        ovf;
        logic        dec;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    hex_bcd_display #(.BLANK_LZ(1'b1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_dec(in_dec),
        .in_ready(rdy1), .busy(busy1), .ovf(ovf1),
        .HEX0(disp1[6:0]),   .HEX1(disp1[13:7]),  .HEX2(disp1[20:14]), .HEX3(disp1[27:21]),
        .HEX4(disp1[34:28]), .HEX5(disp1[41:35]), .HEX6(disp1[48:42]), .HEX7(disp1[55:49])
    );

    hex_bcd_display #(.BLANK_LZ(1'b0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_dec(in_dec),
        .in_ready(rdy0), .busy(busy0), .ovf(ovf0),
        .HEX0(disp0[6:0]),   .HEX1(disp0[13:7]),  .HEX2(disp0[20:14]), .HEX3(disp0[27:21]),
        .HEX4(disp0[34:28]), .HEX5(disp0[41:35]), .HEX6(disp0[48:42]), .HEX7(disp0[55:49])
    );

    function automatic logic [6:0] seg(input logic [3:0] n);
        case (n)
            4'h0: return 7'b1000000;
            4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;
            4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;
            4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;
            4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;
            4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;
            4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;
            default: return 7'b0001110;
        endcase
    endfunction

    function automatic logic [55:0] model(input logic [31:0] d, input logic dec, input logic blz);
        logic [55:0] r;
        logic [31:0] v;
        longint      p;
        r = '0;
        if (!dec) begin
            for (int i = 0; i < 8; i++) r[7*i +: 7] = seg(d[4*i +: 4]);
        end else if (d > 32'd99_999_999) begin
            for (int i = 0; i < 8; i++) r[7*i +: 7] = 7'b0111111;
        end else begin
            v = d;
            p = 1;
            for (int i = 0; i < 8; i++) begin
                if (blz && i > 0 && longint'(d) < p) r[7*i +: 7] = 7'h7F;
                else r[7*i +: 7] = seg(4'(v % 10));
                v = v / 10;
                p = p * 10;
            end
        end
        return r;
    endfunction

    function automatic logic [55:0] reset_disp(input logic blz);
        logic [55:0] r;
        r[6:0] = 7'b1000000;
        for (int i = 1; i < 8; i++) r[7*i +: 7] = blz ? 7'h7F : 7'b1000000;
        return r;
    endfunction

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_hex_blz1"}, 128'(disp1), 128'(reset_disp(1'b1)));
        chk({tag, "_hex_blz0"}, 128'(disp0), 128'(reset_disp(1'b0)));
        chk({tag, "_ovf"},   128'({ovf1, ovf0}),   128'(2'b00));
        chk({tag, "_ready"}, 128'({rdy1, rdy0}),   128'(2'b11));
        chk({tag, "_busy"},  128'({busy1, busy0}), 128'(2'b00));
    endtask

    task automatic send(input logic [31:0] d, input logic dec, input string tag);
        exp_t        e;
        exp_t        got_e;
        logic [112:0] prev;
        int          edges;
        e.h1  = model(d, dec, 1'b1);
        e.h0  = model(d, dec, 1'b0);
        e.ovf = dec && (d > 32'd99_999_999);
        e.dec = dec;
        sb.push_back(e);
        @(negedge clk);
        prev = {ovf1, disp1, disp0};
        in_valid = 1'b1;
        in_data  = d;
        in_dec   = dec;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = $urandom;
        in_dec   = $urandom_range(0, 1);
        chk({tag, "_busy_after_accept"}, 128'({rdy1, busy1}), 128'(2'b01));
        edges = 0;
        while (edges < 100) begin
            @(posedge clk);
            edges++;
            #1;
            if (rdy1) break;
            chk({tag, "_hold"}, 128'({ovf1, disp1, disp0}), 128'(prev));
        end
        got_e = sb.pop_front();
        chk({tag, "_latency"}, 128'(edges), 128'(got_e.dec ? 33 : 1));
        chk({tag, "_hex_blz1"}, 128'(disp1), 128'(got_e.h1));
        chk({tag, "_hex_blz0"}, 128'(disp0), 128'(got_e.h0));
        chk({tag, "_ovf"}, 128'({ovf1, ovf0}), 128'({got_e.ovf, got_e.ovf}));
        chk({tag, "_ready0"}, 128'(rdy0), 128'(1'b1));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        in_dec   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check_reset("reset");

        send(32'hDEADBEEF, 1'b0, "hex_deadbeef");
        send(32'h0123_4567, 1'b0, "hex_b2b");
        send(32'd12_345_678, 1'b1, "dec_12345678");
        send(32'd42, 1'b1, "dec_42");
        send(32'd100_000_000, 1'b1, "dec_ovf");
        send(32'h0, 1'b0, "hex_zero_clears_ovf");
        send(32'd0, 1'b1, "dec_zero");
        send(32'd99_999_999, 1'b1, "dec_max");
        send(32'hFFFF_FFFF, 1'b1, "dec_allones");
        send(32'd1_000, 1'b1, "dec_1000");
        send(32'd90_000_005, 1'b1, "dec_inner_zeros");
        for (int k = 0; k < 4; k++) send($urandom_range(0, 99_999_999), 1'b1, "dec_rand");
        for (int k = 0; k < 3; k++) send($urandom, 1'b0, "hex_rand");

        // Decimal accept, ignored in_valid pulses during conversion, reset at N+10.
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 32'd999;
        in_dec   = 1'b1;
        @(posedge clk);
        #1;
        for (int k = 1; k <= 9; k++) begin
            in_valid = 1'b1;
            in_data  = $urandom;
            in_dec   = 1'b0;
            @(posedge clk);
            #1;
            chk("ignored_valid_busy", 128'({rdy1, rdy0}), 128'(2'b00));
        end
        in_valid = 1'b0;
        rst      = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_reset("midconv_reset");
        send(32'd999, 1'b1, "dec_999_after_reset");

        // Reset on the same edge as an accept: reset wins.
        @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b1;
        in_data  = 32'h1234_5678;
        in_dec   = 1'b0;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        check_reset("reset_vs_accept");
        @(posedge clk);
        #1;
        chk("reset_vs_accept_still_idle", 128'({rdy1, rdy0}), 128'(2'b11));
        chk("reset_vs_accept_hex", 128'(disp1), 128'(reset_disp(1'b1)));

        send(32'h1234_5678, 1'b0, "hex_final");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/hex_bcd_display.md
# hex_bcd_display

Sequential output stage between the CPU's memory-mapped display register and the eight seven-segment displays (HEX0..HEX7) driven out of `top`. It accepts a 32-bit value over a valid/ready handshake and latches per-digit segment patterns. Hex mode renders the raw value as 8 hex digits. Decimal mode runs a one-bit-per-cycle double-dabble binary-to-BCD conversion, with overflow indication and optional leading-zero blanking.

## Interface
- `BLANK_LZ`, default 1: when 1, leading zero digits in decimal mode are blanked; HEX0 is never blanked.
- `clk`  in  1  system clock (CLOCK_50 domain).
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  the CPU presents a new display value.
- `in_data`  in  32  value to display.
- `in_dec`  in  1  1 = decimal mode, 0 = hex mode; sampled only on accept.
- `in_ready`  out  1  block idle and able to accept a value.
- `busy`  out  1  equals `!in_ready`.
- `ovf`  out  1  last accepted decimal value exceeded 99_999_999.
- `HEX0`..`HEX7`  out  7 each  active-low segments, bit order {g,f,e,d,c,b,a}; HEX0 is the least-significant digit.

## Operation
- Accept happens when `in_valid && in_ready`. At accept the block latches `in_data` and `in_dec`. `in_valid` while busy is ignored and not queued.
- FSM states:
  - IDLE: `in_ready`=1. On accept, go to CONV if `in_dec`=1, else go to LOAD.
  - CONV: 32 iterations. Each iteration adds 3 to any BCD nibble ≥5 across 10 nibbles (40-bit BCD register), then shifts left one bit, bringing in the binary MSB. A 5-bit iteration counter reaches 31, then the FSM goes to LOAD.
  - LOAD: register segments for all 8 digits, update `ovf`, go to IDLE.
- Hex mode: digit i = `in_data[4i+3:4i]`, encoded 0-F. `ovf` is cleared.
- Decimal mode, value > 99_999_999 (detected at accept by comparison): all eight HEX = dash (7'b0111111) and `ovf`=1. The conversion still runs its full 32 cycles, so latency is uniform.
- Decimal mode, in range: digit i = BCD nibble i, `ovf`=0. If `BLANK_LZ`=1, every digit above the most-significant nonzero digit is blank (7'h7F). HEX0 always shows its value.
- Reset (any state, including mid-CONV):
  - FSM goes to IDLE; the counter and BCD register clear.
  - `ovf`=0, `in_ready`=1.
  - HEX0 = '0' (7'b1000000).
  - HEX1..HEX7 = blank if `BLANK_LZ`=1, otherwise '0'. The display equals decimal 0.

## Timing
- Accept at edge N.
- Hex mode: LOAD at cycle N+1. HEX and `ovf` are valid after edge N+1, and `in_ready` is high after edge N+1. Back-to-back accept is possible every 2 cycles.
- Decimal mode: CONV covers edges N+1..N+32 and LOAD is edge N+33. Outputs are valid after N+33, and `in_ready` is high after N+33.
- HEX outputs hold their previous value throughout CONV. There are no glitches on the HEX outputs; they are all registered.
- `in_ready` is a registered FSM decode and has no combinational path from `in_valid`.
- Reset asserted on the same edge as an accept: reset wins.

## Structure
- Package `hex_display_pkg` holds:
  - the `state_t` enum {IDLE, CONV, LOAD};
  - `SEG_BLANK` = 7'h7F and `SEG_DASH` = 7'b0111111;
  - digit code constants, active-low:
    - 0-4: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001;
    - 5-9: 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000;
    - A-F: A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
- Sub-module `seg7_encode` is a combinational 4-bit → 7-bit map and is instantiated 8×. The FSM, double-dabble datapath and blanking logic live in `hex_bcd_display`.

## Test plan
- Reset for 2 cycles with `BLANK_LZ`=1 → HEX0=1000000, HEX1..7=7F, `ovf`=0, `in_ready`=1.
- Hex mode, `in_data`=32'hDEADBEEF → after edge N+1, HEX7..HEX0 = d,E,A,d,b,E,E,F codes; `in_ready` is high 1 cycle after accept.
- Decimal mode, 12_345_678 → HEX unchanged through N+32; after edge N+33 HEX7..HEX0 = 1..8 codes and `ovf`=0.
- Decimal mode, 42 with `BLANK_LZ`=1 → HEX1=0011001, HEX0=0100100, HEX2..7=7F. With `BLANK_LZ`=0, HEX2..7 = '0'.
- Decimal mode, 100_000_000 → all HEX = 0111111 and `ovf`=1. A following hex-mode accept of 0 clears `ovf` and shows all '0'.
- Accept decimal 999; pulse `in_valid` with other data during CONV (ignored); assert `rst` at edge N+10 → reset values next cycle. A new accept then behaves normally.
